// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC sequencing with jump redirect, misaligned-target trap, pipeline flush and stall control
module pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        misalign_o
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

    state_t      state, state_d;
    logic [1:0]  cnt, cnt_d;
    logic [31:0] pc_d;
    logic        mis_d;
    logic        accept;
    logic        misaligned;

    assign accept     = jump_en_i && state == RUN;
    assign misaligned = jump_addr_i[1:0] != 2'b00;

    // register PC, FSM state, flush counter and misalign pulse; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= 2'd0;
            pc_o       <= RESET_PC;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pc_o       <= pc_d;
            misalign_o <= mis_d;
        end
    end

    // next-state, next-PC and the combinational flush/stall controls
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pc_d    = pc_o;
        mis_d   = 1'b0;
        flush_o = !rst && (accept || state == FLUSH);
        stall_o = !rst && hold_flag_i && state == RUN && !jump_en_i;
        if (accept) begin
            pc_d  = misaligned ? TRAP_VEC : jump_addr_i;
            mis_d = misaligned;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = CNT_INIT;
            end
        end else if (state == FLUSH) begin
            cnt_d   = cnt == 2'd0 ? 2'd0 : cnt - 2'd1;
            state_d = cnt == 2'd0 ? RUN : FLUSH;
        end else if (!hold_flag_i) begin
            pc_d = pc_o + 32'd4;
        end
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed checks of pc_ctrl with default parameters
module tb_pc_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic [31:0] pc_o;
    logic        flush_o;
    logic        stall_o;
    logic        misalign_o;
    int          checks = 0;
    int          errors = 0;

    pc_ctrl dut (
        .clk(clk),
        .rst(rst),
        .jump_en_i(jump_en_i),
        .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i),
        .pc_o(pc_o),
        .flush_o(flush_o),
        .stall_o(stall_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic fl, input logic st, input logic mi);
        chk({tag, " pc"}, pc_o, pc);
        chk({tag, " flush"}, {31'd0, flush_o}, {31'd0, fl});
        chk({tag, " stall"}, {31'd0, stall_o}, {31'd0, st});
        chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, mi});
    endtask

    initial begin
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 1'b0;
        tick();
        tick();
        jump_en_i = 1'b1; hold_flag_i = 1'b1; jump_addr_i = 32'h40;
        #1;
        chk_all("reset_ctl", 32'h0, 1'b0, 1'b0, 1'b0);
        jump_en_i = 1'b0; hold_flag_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_all("idle0", 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("idle1", 32'h4, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("idle2", 32'h8, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("idle3", 32'hC, 1'b0, 1'b0, 1'b0);
        tick(); chk("idle4 pc", pc_o, 32'h10);
        jump_en_i = 1'b1; jump_addr_i = 32'h40; #1;
        chk_all("jmp_accept", 32'h10, 1'b1, 1'b0, 1'b0);
        tick(); jump_en_i = 1'b0; #1;
        chk_all("jmp_flush", 32'h40, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("jmp_run", 32'h40, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("jmp_next", 32'h44, 1'b0, 1'b0, 1'b0);
        jump_en_i = 1'b1; jump_addr_i = 32'h42; #1;
        chk_all("mis_accept", 32'h44, 1'b1, 1'b0, 1'b0);
        tick(); jump_en_i = 1'b0; #1;
        chk_all("mis_flush", 32'h100, 1'b1, 1'b0, 1'b1);
        tick(); chk_all("mis_run", 32'h100, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("mis_next", 32'h104, 1'b0, 1'b0, 1'b0);
        jump_en_i = 1'b1; jump_addr_i = 32'h3; #1;
        tick(); jump_en_i = 1'b0; #1;
        chk_all("mis_retrig", 32'h100, 1'b1, 1'b0, 1'b1);
        tick(); chk_all("mis_retrig_end", 32'h100, 1'b0, 1'b0, 1'b0);
        jump_en_i = 1'b1; jump_addr_i = 32'h8; #1;
        tick(); jump_en_i = 1'b0; #1;
        tick(); chk_all("to8", 32'h8, 1'b0, 1'b0, 1'b0);
        hold_flag_i = 1'b1; #1;
        chk_all("stall_a", 32'h8, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("stall_b", 32'h8, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("stall_c", 32'h8, 1'b0, 1'b1, 1'b0);
        hold_flag_i = 1'b0; #1;
        tick(); chk_all("stall_release", 32'hC, 1'b0, 1'b0, 1'b0);
        jump_en_i = 1'b1; hold_flag_i = 1'b1; jump_addr_i = 32'h80; #1;
        chk_all("jmp_hold_win", 32'hC, 1'b1, 1'b0, 1'b0);
        tick();
        jump_addr_i = 32'h201; #1;
        chk_all("flush_ignore", 32'h80, 1'b1, 1'b0, 1'b0);
        tick(); jump_en_i = 1'b0; hold_flag_i = 1'b0; #1;
        chk_all("flush_ignored", 32'h80, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("after_ignore", 32'h84, 1'b0, 1'b0, 1'b0);
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC; #1;
        tick(); jump_en_i = 1'b0; #1;
        chk("top_flush pc", pc_o, 32'hFFFF_FFFC);
        tick(); chk_all("top_run", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("wrap", 32'h0, 1'b0, 1'b0, 1'b0);
        jump_en_i = 1'b1; jump_addr_i = 32'h40; #1;
        tick(); jump_en_i = 1'b0; #1;
        chk_all("pre_abort", 32'h40, 1'b1, 1'b0, 1'b0);
        rst = 1'b1; #1;
        chk("abort_rst flush", {31'd0, flush_o}, 32'd0);
        tick(); rst = 1'b0; #1;
        chk_all("abort_release", 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("abort_run", 32'h4, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
